// File: rtl/kerbin_pkg.sv
// Kerbin SoC shared definitions: address map, AXI response codes and the
// AR decoder state encoding.
package kerbin_pkg;

  localparam int unsigned K_NR_ADDR_RULES = 2;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

  // Index 0 = peripherals, index 1 = L2; both bounds inclusive.
  localparam logic [K_NR_ADDR_RULES-1:0][63:0] start_addr_soc = {
    64'h0000_0000_8000_0000,
    64'h0000_0000_1A00_0000
  };
  localparam logic [K_NR_ADDR_RULES-1:0][63:0] end_addr_soc = {
    64'h0000_0000_8100_0000,
    64'h0000_0000_1A00_1FFF
  };

  typedef enum logic [1:0] {
    AR_IDLE = 2'd0,
    AR_HIT  = 2'd1,
    AR_ERR  = 2'd2
  } ar_state_e;

endpackage

// File: rtl/kerbin_addr_match.sv
// Combinational address-rule matcher: one-hot select of the lowest matching
// rule plus a miss flag. Shared by the AR and AW decoders.
module kerbin_addr_match
  import kerbin_pkg::*;
#(
  parameter int unsigned NR_RULES   = K_NR_ADDR_RULES,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter logic [NR_RULES-1:0][ADDR_WIDTH-1:0] START_ADDR = start_addr_soc,
  parameter logic [NR_RULES-1:0][ADDR_WIDTH-1:0] END_ADDR   = end_addr_soc
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NR_RULES-1:0]   sel,
  output logic                  miss
);

  logic [NR_RULES-1:0] raw_hit_s;

  for (genvar i = 0; i < NR_RULES; i++) begin : g_rule
    assign raw_hit_s[i] = (addr >= START_ADDR[i]) && (addr <= END_ADDR[i]);
  end

  // Isolate the lowest set bit so overlapping rules still give a one-hot select.
  assign sel  = raw_hit_s & (~raw_hit_s + {{(NR_RULES-1){1'b0}}, 1'b1});
  assign miss = ~|raw_hit_s;

endmodule

// File: rtl/kerbin_ar_decoder.sv
// AXI AR-channel decoder: one-entry register stage with one-hot slave select,
// and a local DECERR responder for requests that hit no address rule.
module kerbin_ar_decoder
  import kerbin_pkg::*;
#(
  parameter int unsigned NR_RULES   = K_NR_ADDR_RULES,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [NR_RULES-1:0][ADDR_WIDTH-1:0] START_ADDR = start_addr_soc,
  parameter logic [NR_RULES-1:0][ADDR_WIDTH-1:0] END_ADDR   = end_addr_soc
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [7:0]            ar_len_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [ID_WIDTH-1:0]   m_id_o,
  output logic [7:0]            m_len_o,
  output logic [NR_RULES-1:0]   m_sel_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o
);

  ar_state_e             state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ID_WIDTH-1:0]   id_r;
  logic [7:0]            len_r;
  logic [NR_RULES-1:0]   sel_r;
  logic [7:0]            cnt_r;
  logic [NR_RULES-1:0]   dec_sel_s;
  logic                  dec_miss_s;
  logic                  accept_s;
  logic                  last_beat_s;
  logic                  beat_done_s;

  kerbin_addr_match #(
    .NR_RULES   (NR_RULES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_match (
    .addr (ar_addr_i),
    .sel  (dec_sel_s),
    .miss (dec_miss_s)
  );

  assign accept_s    = ar_valid_i & ar_ready_o;
  assign last_beat_s = (cnt_r == len_r);
  assign beat_done_s = r_valid_o & r_ready_i;

  // Next-state and upstream ready; HIT passes m_ready_i through for full throughput.
  always_comb begin
    state_s    = state_r;
    ar_ready_o = 1'b0;
    case (state_r)
      AR_IDLE: begin
        ar_ready_o = 1'b1;
        if (accept_s) begin
          state_s = dec_miss_s ? AR_ERR : AR_HIT;
        end else begin
          state_s = AR_IDLE;
        end
      end
      AR_HIT: begin
        ar_ready_o = m_ready_i;
        if (m_ready_i && accept_s) begin
          state_s = dec_miss_s ? AR_ERR : AR_HIT;
        end else if (m_ready_i) begin
          state_s = AR_IDLE;
        end else begin
          state_s = AR_HIT;
        end
      end
      AR_ERR: begin
        ar_ready_o = 1'b0;
        if (beat_done_s && last_beat_s) begin
          state_s = AR_IDLE;
        end else begin
          state_s = AR_ERR;
        end
      end
      default: begin
        ar_ready_o = 1'b0;
        state_s    = AR_IDLE;
      end
    endcase
  end

  // State register and request capture; a miss loads an all-zero select.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= AR_IDLE;
      addr_r  <= '0;
      id_r    <= '0;
      len_r   <= 8'd0;
      sel_r   <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        addr_r <= ar_addr_i;
        id_r   <= ar_id_i;
        len_r  <= ar_len_i;
        sel_r  <= dec_sel_s;
      end else begin
        addr_r <= addr_r;
        id_r   <= id_r;
        len_r  <= len_r;
        sel_r  <= sel_r;
      end
    end
  end

  // Error beat counter; stops at len (255 at most) and clears on the last beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_r <= 8'd0;
    end else if (beat_done_s) begin
      cnt_r <= last_beat_s ? 8'd0 : cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign m_valid_o = (state_r == AR_HIT);
  assign m_addr_o  = addr_r;
  assign m_id_o    = id_r;
  assign m_len_o   = len_r;
  assign m_sel_o   = sel_r;

  assign r_valid_o = (state_r == AR_ERR);
  assign r_id_o    = id_r;
  assign r_data_o  = '0;
  assign r_resp_o  = r_valid_o ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  assign r_last_o  = r_valid_o & last_beat_s;

endmodule

// File: tb/tb_kerbin_ar_decoder.sv
// Self-checking bench for kerbin_ar_decoder: directed steps plus random
// traffic, scored against a queue-based model of the address map.
module tb_kerbin_ar_decoder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ar_valid_i = 1'b0;
  logic        ar_ready_o;
  logic [63:0] ar_addr_i = 64'd0;
  logic [3:0]  ar_id_i = 4'd0;
  logic [7:0]  ar_len_i = 8'd0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic [63:0] m_addr_o;
  logic [3:0]  m_id_o;
  logic [7:0]  m_len_o;
  logic [1:0]  m_sel_o;
  logic        r_valid_o;
  logic        r_ready_i = 1'b1;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;

  always #5 clk_i = ~clk_i;

  kerbin_ar_decoder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_addr_o(m_addr_o),
    .m_id_o(m_id_o), .m_len_o(m_len_o), .m_sel_o(m_sel_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o)
  );

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [1:0]  sel;
    bit          miss;
  } req_t;

  localparam logic [63:0] RS [2] = '{64'h1A00_0000, 64'h8000_0000};
  localparam logic [63:0] RE [2] = '{64'h1A00_1FFF, 64'h8100_0000};

  req_t q[$];
  int   beat = 0;
  int   total = 0;
  int   bad = 0;
  bit   last_acc = 1'b0;

  function automatic logic [1:0] ref_sel(logic [63:0] a);
    for (int i = 0; i < 2; i++) begin
      if (a >= RS[i] && a <= RE[i]) return 2'(1 << i);
    end
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score outputs against the model, then advance past the edge.
  task automatic tick();
    logic exp_ready;
    bit   acc;
    req_t n;
    #1;
    acc = 1'b0;
    if (rst_ni) begin
      chk("valid_excl", {63'd0, m_valid_o & r_valid_o}, 64'd0);
      chk("occupancy", {63'd0, m_valid_o | r_valid_o}, {63'd0, q.size() != 0});
      exp_ready = (q.size() == 0) ? 1'b1 : (q[0].miss ? 1'b0 : m_ready_i);
      chk("ar_ready", {63'd0, ar_ready_o}, {63'd0, exp_ready});
      if (q.size() != 0) begin
        if (!q[0].miss) begin
          chk("m_valid", {63'd0, m_valid_o}, 64'd1);
          chk("m_addr", m_addr_o, q[0].addr);
          chk("m_id", {60'd0, m_id_o}, {60'd0, q[0].id});
          chk("m_len", {56'd0, m_len_o}, {56'd0, q[0].len});
          chk("m_sel", {62'd0, m_sel_o}, {62'd0, q[0].sel});
          if (m_ready_i) void'(q.pop_front());
        end else begin
          chk("r_valid", {63'd0, r_valid_o}, 64'd1);
          chk("r_id", {60'd0, r_id_o}, {60'd0, q[0].id});
          chk("r_data", r_data_o, 64'd0);
          chk("r_resp", {62'd0, r_resp_o}, 64'd3);
          chk("r_last", {63'd0, r_last_o}, {63'd0, beat == int'(q[0].len)});
          if (r_ready_i) begin
            if (beat == int'(q[0].len)) begin
              void'(q.pop_front());
              beat = 0;
            end else begin
              beat++;
            end
          end
        end
      end
      acc = ar_valid_i & ar_ready_o;
      if (acc) begin
        n.addr = ar_addr_i;
        n.id   = ar_id_i;
        n.len  = ar_len_i;
        n.sel  = ref_sel(ar_addr_i);
        n.miss = (n.sel == 2'b00);
        q.push_back(n);
      end
    end
    @(posedge clk_i);
    if (!rst_ni) begin
      q.delete();
      beat = 0;
    end
    last_acc = acc;
    @(negedge clk_i);
  endtask

  task automatic send(input logic [63:0] a, input logic [3:0] id, input logic [7:0] len,
                      output int n);
    ar_valid_i = 1'b1;
    ar_addr_i  = a;
    ar_id_i    = id;
    ar_len_i   = len;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 2000);
    if (!last_acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int cycles);
    ar_valid_i = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  logic [63:0] pool [10] = '{64'h1A00_0000, 64'h1A00_1FFF, 64'h1A00_2000, 64'h19FF_FFFF,
                             64'h8000_0000, 64'h8100_0000, 64'h8100_0001, 64'h7FFF_FFFF,
                             64'h1_8000_0000, 64'h0000_1000};

  initial begin
    int n;
    int cyc;
    logic [63:0] a;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_m_valid", {63'd0, m_valid_o}, 64'd0);
    chk("rst_r_valid", {63'd0, r_valid_o}, 64'd0);
    chk("rst_r_last", {63'd0, r_last_o}, 64'd0);
    chk("rst_m_sel", {62'd0, m_sel_o}, 64'd0);
    chk("rst_m_addr", m_addr_o, 64'd0);
    chk("rst_m_id", {60'd0, m_id_o}, 64'd0);
    chk("rst_r_data", r_data_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drain(2);

    // Directed hits, boundary addresses and a single-beat miss.
    send(64'h1A00_0010, 4'd3, 8'd0, n);
    drain(2);
    send(64'h8100_0000, 4'd1, 8'd2, n);
    send(64'h8000_0000, 4'd2, 8'd1, n);
    send(64'h1A00_2000, 4'd4, 8'd0, n);
    send(64'h1A00_1FFF, 4'd6, 8'd0, n);
    send(64'h19FF_FFFF, 4'd7, 8'd0, n);
    send(64'h8100_0001, 4'd8, 8'd0, n);
    drain(3);

    // Four-beat DECERR burst.
    send(64'h0000_1000, 4'd5, 8'd3, n);
    drain(6);

    // Downstream backpressure on a hit.
    m_ready_i = 1'b0;
    send(64'h8000_0040, 4'd9, 8'd4, n);
    drain(5);
    m_ready_i = 1'b1;
    drain(2);

    // Back-to-back hits: each accept should take exactly one cycle.
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      send(64'h8000_0100 + 64'(k * 16), 4'(k), 8'(k), n);
      cyc += n;
    end
    chk("b2b_cycles", 64'(cyc), 64'd8);
    send(64'h0000_2000, 4'd12, 8'd2, n);
    send(64'h1A00_0100, 4'd13, 8'd0, n);
    send(64'h1A00_0200, 4'd14, 8'd0, n);
    drain(3);

    // Reset aborts an in-flight error burst.
    send(64'h0000_3000, 4'd10, 8'd7, n);
    ar_valid_i = 1'b0;
    tick();
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    chk("abort_r_valid", {63'd0, r_valid_o}, 64'd0);
    chk("abort_m_valid", {63'd0, m_valid_o}, 64'd0);
    #1;
    tick();
    send(64'h0000_4000, 4'd11, 8'd0, n);
    drain(3);

    // Maximum-length burst with random R backpressure.
    send(64'h0000_5000, 4'd15, 8'd255, n);
    ar_valid_i = 1'b0;
    for (int i = 0; i < 700 && q.size() != 0; i++) begin
      r_ready_i = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    chk("len255_drained", 64'(q.size()), 64'd0);
    r_ready_i = 1'b1;

    // Random traffic; ar_valid stays up until its handshake.
    for (int i = 0; i < 1500; i++) begin
      if (!ar_valid_i || last_acc) begin
        ar_valid_i = 1'($urandom_range(0, 2) != 0);
        a = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : pool[$urandom_range(0, 9)];
        ar_addr_i = a;
        ar_id_i   = 4'($urandom);
        ar_len_i  = 8'($urandom_range(0, 7));
      end
      m_ready_i = 1'($urandom_range(0, 3) != 0);
      r_ready_i = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    m_ready_i = 1'b1;
    r_ready_i = 1'b1;
    drain(20);
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
